jpeg_rle_expander: RTL



---
 rtl/jpeg_pkg.sv | 24 ++
 rtl/jpeg_coef_oreg.sv | 55 +++++
 rtl/jpeg_rle_expander.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG coefficient-path definitions: block geometry, run field width
// and the run-length expander state encoding.
package jpeg_pkg;

  localparam int NCOEF_DEFAULT = 64;
  localparam int RUN_W         = 4;
  localparam int ZRL_RUN       = 15;
  localparam int VW_DEFAULT    = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ZEROS = 2'd1,
    VALUE = 2'd2,
    FILL  = 2'd3
  } rle_state_t;

  // One run-length symbol as exchanged between packer and expander.
  typedef struct packed {
    logic [RUN_W-1:0]      run;
    logic [VW_DEFAULT-1:0] value;
    logic                  eob;
  } rle_sym_t;

endpackage

// File: rtl/jpeg_coef_oreg.sv
// One-entry output register for the coefficient stream. Payload is held
// stable while out_valid_o=1 and out_ready_i=0; the entry is only replaced
// or emptied on a cycle where it is being drained (or is already empty).
module jpeg_coef_oreg #(
  parameter int VW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [VW-1:0] in_coef_i,
  input  logic [5:0]    in_index_i,
  input  logic          in_last_i,
  input  logic          in_flag_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [VW-1:0] out_coef_o,
  output logic [5:0]    out_index_o,
  output logic          out_last_o,
  output logic          out_flag_o
);

  logic          valid_q;
  logic [VW-1:0] coef_q;
  logic [5:0]    index_q;
  logic          last_q;
  logic          flag_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_coef_o  = coef_q;
  assign out_index_o = index_q;
  assign out_last_o  = last_q;
  assign out_flag_o  = flag_q;

  // Load a new entry only when the current one is absent or leaving.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      coef_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        coef_q  <= in_coef_i;
        index_q <= in_index_i;
        last_q  <= in_last_i;
        flag_q  <= in_flag_i;
      end
    end
  end

endmodule

// File: rtl/jpeg_rle_expander.sv
// JPEG run-length expander: turns (run, value) / EOB symbols into exactly
// NCOEF coefficients per block in zigzag order.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never drops and payload never changes until that transfer.
module jpeg_rle_expander
  import jpeg_pkg::*;
#(
  parameter int VW    = 12,
  parameter int NCOEF = NCOEF_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [RUN_W-1:0] s_run,
  input  logic [VW-1:0]    s_value,
  input  logic             s_eob,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [VW-1:0]    m_coef,
  output logic [5:0]       m_index,
  output logic             m_last,
  output logic             err_overflow,
  output logic [1:0]       dbg_state
);

  localparam logic [5:0] LAST_IDX = 6'(NCOEF - 1);

  rle_state_t       state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [RUN_W-1:0] run_q, run_d;   // zeros still to emit, including current
  logic [VW-1:0]    val_q, val_d;

  logic          ld_ok;
  logic          accept;
  logic          at_last;
  logic          gen_valid;
  logic [VW-1:0] gen_coef;
  logic          gen_ovf;
  logic          out_ovf;

  assign at_last   = (idx_q == LAST_IDX);
  assign s_ready   = !rst && (state_q == IDLE) && ld_ok;
  assign accept    = s_valid && s_ready;
  assign dbg_state = state_q;

  // Produce at most one coefficient per cycle whenever the output slot is free.
  // The symbol's first coefficient is generated in its acceptance cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    run_d     = run_q;
    val_d     = val_q;
    gen_valid = 1'b0;
    gen_coef  = '0;
    gen_ovf   = 1'b0;
    if (ld_ok) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            gen_valid = 1'b1;
            val_d     = s_value;
            if (s_eob) begin
              state_d = at_last ? IDLE : FILL;
            end else if (s_run != '0) begin
              run_d = s_run - 4'd1;
              if (at_last) begin
                gen_ovf = 1'b1;            // value would land past the block
                state_d = IDLE;
              end else begin
                state_d = (s_run == 4'd1) ? VALUE : ZEROS;
              end
            end else begin
              gen_coef = s_value;
              state_d  = IDLE;
            end
          end
        end
        ZEROS: begin
          gen_valid = 1'b1;
          run_d     = run_q - 4'd1;
          if (at_last) begin
            gen_ovf = 1'b1;
            state_d = IDLE;
          end else if (run_q == 4'd1) begin
            state_d = VALUE;
          end
        end
        VALUE: begin
          gen_valid = 1'b1;
          gen_coef  = val_q;
          state_d   = IDLE;
        end
        FILL: begin
          gen_valid = 1'b1;
          if (at_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (gen_valid) idx_d = at_last ? 6'd0 : idx_q + 6'd1;
    end
  end

  // Symbol/FSM state; reset discards any partial block silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      run_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      val_q   <= val_d;
    end
  end

  jpeg_coef_oreg #(.VW(VW)) u_oreg (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (gen_valid),
    .in_ready_o  (ld_ok),
    .in_coef_i   (gen_coef),
    .in_index_i  (idx_q),
    .in_last_i   (at_last),
    .in_flag_i   (gen_ovf),
    .out_valid_o (m_valid),
    .out_ready_i (m_ready),
    .out_coef_o  (m_coef),
    .out_index_o (m_index),
    .out_last_o  (m_last),
    .out_flag_o  (out_ovf)
  );

  // The overflow flag travels with the truncated coefficient and pulses on
  // the cycle that coefficient is handed over.
  assign err_overflow = m_valid && m_ready && out_ovf;

endmodule
